// File: rtl/mlbx_cfg_sequencer.sv
// mlbx_cfg_sequencer: run-time configuration controller for the 3-level
// NPC/NPP/ANPC switch decoder of the MLBX leg. Each accepted configuration
// is applied in four steps: park the leg at the zero level, blank all gates,
// hold the decoder while the new set loads, then release it.
//
// Optional feature macro: MLBX_CFG_ZERO_WAIT_EN
//   When defined, an accepted valid set waits in WAIT until the modulator
//   requests the zero level. The leg then parks at a natural zero crossing.
//   When undefined, WAIT does not exist and PARK follows validation directly.
//
// Handshake: a configuration transfers on a rising clk edge where
// cfg_valid && cfg_ready. cfg_ready is high only in RUN with no set pending
// validation. The cfg_* inputs are sampled on that edge, and ce is not
// required for the transfer. A master may hold cfg_valid high while busy. The
// transfer then happens in the first RUN cycle in which cfg_ready is high.
module mlbx_cfg_sequencer #(
  parameter int          TW     = 10,
  parameter int          SW     = 16,
  parameter logic [1:0]  V_ZERO = 2'd1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_npc_type,
  input  logic [1:0]    cfg_comm_type,
  input  logic [TW-1:0] cfg_t_short,
  input  logic [TW-1:0] cfg_t_off_on,
  input  logic [TW-1:0] cfg_t_on_offv0,
  input  logic [TW-1:0] cfg_t_offv0_on,
  input  logic [TW-1:0] cfg_t_off_oni0,
  input  logic [SW-1:0] cfg_settle,
  input  logic [1:0]    v_lev_in,
  output logic [1:0]    v_lev_out,
  output logic [1:0]    npc_type_out,
  output logic [1:0]    comm_type_out,
  output logic [TW-1:0] t_short_out,
  output logic [TW-1:0] t_off_on_out,
  output logic [TW-1:0] t_on_offv0_out,
  output logic [TW-1:0] t_offv0_on_out,
  output logic [TW-1:0] t_off_oni0_out,
  output logic          dec_hold,
  output logic          busy,
  output logic          cfg_err,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_PARK    = 3'd1,
    S_BLANK   = 3'd2,
    S_LOAD    = 3'd3,
    S_RELEASE = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  state_t        state;
  logic [SW-1:0] cnt;
  logic          pending;

  // Shadow copy of the most recently accepted configuration.
  logic [1:0]    sh_npc_type;
  logic [1:0]    sh_comm_type;
  logic [TW-1:0] sh_t_short;
  logic [TW-1:0] sh_t_off_on;
  logic [TW-1:0] sh_t_on_offv0;
  logic [TW-1:0] sh_t_offv0_on;
  logic [TW-1:0] sh_t_off_oni0;
  logic [SW-1:0] sh_settle;

  logic          accept;
  logic          set_ok;
  logic [SW-1:0] cnt_load;

  // Ready is withheld during the validation cycle, so a second offer cannot
  // overwrite the shadow set before it has been checked.
  assign cfg_ready = (state == S_RUN) && !pending;
  assign accept    = cfg_valid && cfg_ready;
  assign busy      = (state != S_RUN);
  assign state_dbg = state;
  assign set_ok    = (sh_t_short != '0) && (sh_settle != '0);
  // The counter runs settle-1 down to 0, giving settle ce-cycles per step.
  // settle is non-zero once validated, so the full SW range never wraps.
  assign cnt_load  = sh_settle - 1'b1;

  // Sequencer FSM. It owns the shadow latch and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_RUN;
      cnt            <= '0;
      pending        <= 1'b0;
      sh_npc_type    <= '0;
      sh_comm_type   <= '0;
      sh_t_short     <= '0;
      sh_t_off_on    <= '0;
      sh_t_on_offv0  <= '0;
      sh_t_offv0_on  <= '0;
      sh_t_off_oni0  <= '0;
      sh_settle      <= '0;
      v_lev_out      <= V_ZERO;
      npc_type_out   <= '0;
      comm_type_out  <= '0;
      t_short_out    <= '0;
      t_off_on_out   <= '0;
      t_on_offv0_out <= '0;
      t_offv0_on_out <= '0;
      t_off_oni0_out <= '0;
      dec_hold       <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (accept) begin
        sh_npc_type   <= cfg_npc_type;
        sh_comm_type  <= cfg_comm_type;
        sh_t_short    <= cfg_t_short;
        sh_t_off_on   <= cfg_t_off_on;
        sh_t_on_offv0 <= cfg_t_on_offv0;
        sh_t_offv0_on <= cfg_t_offv0_on;
        sh_t_off_oni0 <= cfg_t_off_oni0;
        sh_settle     <= cfg_settle;
        pending       <= 1'b1;
      end
      if (ce) begin
        case (state)
          S_RUN: begin
            v_lev_out <= v_lev_in;
            if (pending) begin
              pending <= 1'b0;
              if (!set_ok) begin
                cfg_err <= 1'b1;
              end else begin
`ifdef MLBX_CFG_ZERO_WAIT_EN
                state <= S_WAIT;
`else
                state     <= S_PARK;
                cnt       <= cnt_load;
                v_lev_out <= V_ZERO;
`endif
              end
            end
          end
          S_WAIT: begin
            v_lev_out <= v_lev_in;
            if (v_lev_in == V_ZERO) begin
              state <= S_PARK;
              cnt   <= cnt_load;
            end
          end
          S_PARK: begin
            if (cnt == '0) begin
              state        <= S_BLANK;
              cnt          <= cnt_load;
              npc_type_out <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_BLANK: begin
            if (cnt == '0) begin
              state          <= S_LOAD;
              dec_hold       <= 1'b1;
              comm_type_out  <= sh_comm_type;
              t_short_out    <= sh_t_short;
              t_off_on_out   <= sh_t_off_on;
              t_on_offv0_out <= sh_t_on_offv0;
              t_offv0_on_out <= sh_t_offv0_on;
              t_off_oni0_out <= sh_t_off_oni0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_LOAD: begin
            state        <= S_RELEASE;
            dec_hold     <= 1'b0;
            npc_type_out <= sh_npc_type;
            cnt          <= cnt_load;
          end
          S_RELEASE: begin
            if (cnt == '0) begin
              state <= S_RUN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state     <= S_RUN;
            dec_hold  <= 1'b0;
            v_lev_out <= V_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlbx_cfg_sequencer.sv
// Directed testbench for mlbx_cfg_sequencer.
module tb_mlbx_cfg_sequencer;
  localparam int TW = 10;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_npc_type;
  logic [1:0]    cfg_comm_type;
  logic [TW-1:0] cfg_t_short, cfg_t_off_on, cfg_t_on_offv0, cfg_t_offv0_on, cfg_t_off_oni0;
  logic [SW-1:0] cfg_settle;
  logic [1:0]    v_lev_in;
  logic [1:0]    v_lev_out;
  logic [1:0]    npc_type_out, comm_type_out;
  logic [TW-1:0] t_short_out, t_off_on_out, t_on_offv0_out, t_offv0_on_out, t_off_oni0_out;
  logic          dec_hold, busy, cfg_err;
  logic [2:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  mlbx_cfg_sequencer #(.TW(TW), .SW(SW), .V_ZERO(2'd1)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_npc_type(cfg_npc_type), .cfg_comm_type(cfg_comm_type),
    .cfg_t_short(cfg_t_short), .cfg_t_off_on(cfg_t_off_on),
    .cfg_t_on_offv0(cfg_t_on_offv0), .cfg_t_offv0_on(cfg_t_offv0_on),
    .cfg_t_off_oni0(cfg_t_off_oni0), .cfg_settle(cfg_settle),
    .v_lev_in(v_lev_in), .v_lev_out(v_lev_out),
    .npc_type_out(npc_type_out), .comm_type_out(comm_type_out),
    .t_short_out(t_short_out), .t_off_on_out(t_off_on_out),
    .t_on_offv0_out(t_on_offv0_out), .t_offv0_on_out(t_offv0_on_out),
    .t_off_oni0_out(t_off_oni0_out),
    .dec_hold(dec_hold), .busy(busy), .cfg_err(cfg_err), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock and sample 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a configuration; the four secondary timing values are offsets of t_short
  task automatic set_cfg(input logic [1:0] npc, input logic [1:0] comm,
                         input logic [TW-1:0] ts, input logic [SW-1:0] st);
    cfg_npc_type   = npc;
    cfg_comm_type  = comm;
    cfg_t_short    = ts;
    cfg_t_off_on   = ts + 10'd1;
    cfg_t_on_offv0 = ts + 10'd2;
    cfg_t_offv0_on = ts + 10'd3;
    cfg_t_off_oni0 = ts + 10'd4;
    cfg_settle     = st;
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b0; cfg_valid = 1'b0; v_lev_in = 2'd1;
    set_cfg(2'd0, 2'd0, 10'd0, 16'd0);
    repeat (3) tick();
    n_tests++;
    if (v_lev_out !== 2'd1 || npc_type_out !== 2'd0 || dec_hold !== 1'b0 || busy !== 1'b0 ||
        cfg_err !== 1'b0 || t_short_out !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got v_lev=%0d npc=%0d hold=%0b busy=%0b err=%0b ts=%0d, required 1 0 0 0 0 0",
               v_lev_out, npc_type_out, dec_hold, busy, cfg_err, t_short_out);
    end
    rst = 1'b1; ce = 1'b1;
    tick();
    n_tests++;
    if (v_lev_out !== 2'd1 || npc_type_out !== 2'd0 || dec_hold !== 1'b0 ||
        cfg_ready !== 1'b1 || busy !== 1'b0 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: got v_lev=%0d npc=%0d hold=%0b ready=%0b busy=%0b state=%0d, required 1 0 0 1 0 0",
               v_lev_out, npc_type_out, dec_hold, cfg_ready, busy, state_dbg);
    end
  endtask

  // Full apply sequence; expectations come from the step lengths:
  // after ce-edge k (k=1 is validation) PARK k<=s, BLANK s<k<=2s, LOAD k=2s+1,
  // RELEASE 2s+1<k<=3s+1, RUN at k=3s+2.
  task automatic test_apply(input logic [1:0] npc, input logic [1:0] comm,
                            input logic [TW-1:0] ts, input logic [SW-1:0] st,
                            input logic [1:0] prev_npc, input logic [1:0] prev_comm,
                            input logic [TW-1:0] prev_ts, input logic [1:0] trk,
                            input bit toggle, input string name);
    int s, last, k, cyc, exp_cyc;
    logic [1:0]    e_vlev, e_npc, e_comm;
    logic [TW-1:0] e_ts;
    logic          e_hold, e_busy;
    s = int'(st); last = 3 * s + 2; k = 0; cyc = 0;
    ce = 1'b1; v_lev_in = trk;
    tick();
    n_tests++;
    if (v_lev_out !== trk) begin
      n_fail++;
      $display("FAIL %s track_before: got v_lev=%0d, required %0d", name, v_lev_out, trk);
    end
    set_cfg(npc, comm, ts, st);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    while (k < last && cyc < 400) begin
      ce = toggle ? ((cyc % 2) == 0) : 1'b1;
      tick();
      cyc++;
      if (ce) k++;
      e_vlev = (k == 0) ? trk : 2'd1;
      e_busy = (k >= 1) && (k < last);
      e_hold = (k == 2 * s + 1);
      e_npc  = (k <= s) ? prev_npc : ((k <= 2 * s + 1) ? 2'd0 : npc);
      e_ts   = (k <= 2 * s) ? prev_ts : ts;
      e_comm = (k <= 2 * s) ? prev_comm : comm;
      n_tests++;
      if (v_lev_out !== e_vlev || busy !== e_busy || dec_hold !== e_hold ||
          npc_type_out !== e_npc || t_short_out !== e_ts || comm_type_out !== e_comm) begin
        n_fail++;
        $display("FAIL %s seq k=%0d cyc=%0d: got v_lev=%0d busy=%0b hold=%0b npc=%0d ts=%0d comm=%0d, required %0d %0b %0b %0d %0d %0d",
                 name, k, cyc, v_lev_out, busy, dec_hold, npc_type_out, t_short_out, comm_type_out,
                 e_vlev, e_busy, e_hold, e_npc, e_ts, e_comm);
      end
    end
    ce = 1'b1;
    exp_cyc = toggle ? (2 * last - 1) : last;
    n_tests++;
    if (cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL %s length: got %0d clk cycles, required %0d", name, cyc, exp_cyc);
    end
    n_tests++;
    if (t_off_on_out !== ts + 10'd1 || t_on_offv0_out !== ts + 10'd2 ||
        t_offv0_on_out !== ts + 10'd3 || t_off_oni0_out !== ts + 10'd4) begin
      n_fail++;
      $display("FAIL %s timings: got %0d %0d %0d %0d, required %0d %0d %0d %0d", name,
               t_off_on_out, t_on_offv0_out, t_offv0_on_out, t_off_oni0_out,
               ts + 10'd1, ts + 10'd2, ts + 10'd3, ts + 10'd4);
    end
    tick();
    n_tests++;
    if (v_lev_out !== trk || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s track_after: got v_lev=%0d ready=%0b busy=%0b, required %0d 1 0",
               name, v_lev_out, cfg_ready, busy, trk);
    end
  endtask

  // Rejected sets pulse cfg_err once and leave the active set alone
  task automatic test_reject(input logic [TW-1:0] ts, input logic [SW-1:0] st,
                             input logic [1:0] act_npc, input logic [TW-1:0] act_ts,
                             input string name);
    ce = 1'b1;
    set_cfg(2'd2, 2'd1, ts, st);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    n_tests++;
    if (cfg_err !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: got err=%0b busy=%0b ready=%0b, required 0 0 0", name, cfg_err, busy, cfg_ready);
    end
    tick();
    n_tests++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || npc_type_out !== act_npc || t_short_out !== act_ts) begin
      n_fail++;
      $display("FAIL %s pulse: got err=%0b busy=%0b npc=%0d ts=%0d, required 1 0 %0d %0d",
               name, cfg_err, busy, npc_type_out, t_short_out, act_npc, act_ts);
    end
    tick();
    n_tests++;
    if (cfg_err !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after: got err=%0b busy=%0b ready=%0b, required 0 0 1", name, cfg_err, busy, cfg_ready);
    end
  endtask

  // Asynchronous reset asserted while the sequence is in BLANK
  task automatic test_reset_mid();
    ce = 1'b1; v_lev_in = 2'd2;
    set_cfg(2'd2, 2'd3, 10'd9, 16'd3);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (state_dbg !== 3'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre: got state=%0d busy=%0b, required 2 1", state_dbg, busy);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (v_lev_out !== 2'd1 || npc_type_out !== 2'd0 || t_short_out !== 10'd0 || busy !== 1'b0 ||
        dec_hold !== 1'b0 || cfg_ready !== 1'b1 || comm_type_out !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid async: got v_lev=%0d npc=%0d ts=%0d busy=%0b hold=%0b ready=%0b comm=%0d, required 1 0 0 0 0 1 0",
               v_lev_out, npc_type_out, t_short_out, busy, dec_hold, cfg_ready, comm_type_out);
    end
    tick();
    rst = 1'b1;
  endtask

  // cfg_valid held high while busy is taken in the first RUN cycle
  task automatic test_back_to_back();
    int n;
    ce = 1'b1;
    set_cfg(2'd2, 2'd3, 10'd30, 16'd1);
    cfg_valid = 1'b1;
    tick();
    set_cfg(2'd1, 2'd1, 10'd40, 16'd2);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (cfg_ready === 1'b1) break;
    end
    n_tests++;
    if (n !== 5 || t_short_out !== 10'd30 || npc_type_out !== 2'd2) begin
      n_fail++;
      $display("FAIL b2b first: got ready after %0d edges ts=%0d npc=%0d, required 5 30 2", n, t_short_out, npc_type_out);
    end
    tick();
    n_tests++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b accept: got ready=%0b busy=%0b, required 0 0", cfg_ready, busy);
    end
    cfg_valid = 1'b0;
    n = 0;
    while (n < 30) begin
      tick();
      n++;
      if (busy === 1'b0) break;
    end
    n_tests++;
    if (n !== 8 || t_short_out !== 10'd40 || npc_type_out !== 2'd1 || comm_type_out !== 2'd1) begin
      n_fail++;
      $display("FAIL b2b second: got busy low after %0d edges ts=%0d npc=%0d comm=%0d, required 8 40 1 1",
               n, t_short_out, npc_type_out, comm_type_out);
    end
  endtask

`ifdef MLBX_CFG_ZERO_WAIT_EN
  // Parking waits for the modulator to request the zero level
  task automatic test_zero_wait();
    int n;
    ce = 1'b1; v_lev_in = 2'd2;
    set_cfg(2'd3, 2'd0, 10'd5, 16'd1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (busy !== 1'b1 || state_dbg !== 3'd5 || v_lev_out !== 2'd2) begin
        n_fail++;
        $display("FAIL zero_wait hold i=%0d: got busy=%0b state=%0d v_lev=%0d, required 1 5 2",
                 i, busy, state_dbg, v_lev_out);
      end
    end
    v_lev_in = 2'd1;
    tick();
    n_tests++;
    if (state_dbg !== 3'd1 || v_lev_out !== 2'd1) begin
      n_fail++;
      $display("FAIL zero_wait park: got state=%0d v_lev=%0d, required 1 1", state_dbg, v_lev_out);
    end
    n = 0;
    while (n < 20 && busy === 1'b1) begin
      tick();
      n++;
    end
    n_tests++;
    if (busy !== 1'b0 || npc_type_out !== 2'd3 || t_short_out !== 10'd5) begin
      n_fail++;
      $display("FAIL zero_wait done: got busy=%0b npc=%0d ts=%0d, required 0 3 5", busy, npc_type_out, t_short_out);
    end
  endtask
`endif

  // Test sequence and final report
  initial begin
    test_reset();
`ifdef MLBX_CFG_ZERO_WAIT_EN
    test_zero_wait();
`else
    test_apply(2'd3, 2'd2, 10'd5, 16'd4, 2'd0, 2'd0, 10'd0, 2'd2, 1'b0, "anpc");
    test_reject(10'd0, 16'd4, 2'd3, 10'd5, "rej_tshort");
    test_reject(10'd7, 16'd0, 2'd3, 10'd5, "rej_settle");
    test_apply(2'd1, 2'd0, 10'd20, 16'd4, 2'd3, 2'd2, 10'd5, 2'd3, 1'b1, "ce_toggle");
    test_reset_mid();
    test_apply(2'd2, 2'd1, 10'd6, 16'd2, 2'd0, 2'd0, 10'd0, 2'd0, 1'b0, "after_rst");
    test_back_to_back();
    test_apply(2'd0, 2'd2, 10'd100, 16'd1, 2'd1, 2'd1, 10'd40, 2'd2, 1'b0, "noout");
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
